fetch: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues reads to the synchronous instruction RAM and hands instructions to decode over IF_ID_bus. It is the consuming end of the write-back redirect interface. exc_bus/cancel from write-back and jbr_bus from decode steer the PC, discarding any in-flight fetch.

---
 rtl/fetch.sv | 145 ++++++++++++++
 tb/tb_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// fetch: instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the PC, issues reads to a synchronous instruction RAM (data valid the
// cycle after inst_en) and hands instructions to decode over IF_ID_bus.
// Redirects come from decode (jbr_bus, only on a handoff) and from write-back
// (exc_bus / cancel, which discard anything in flight or held).
//
// Optional feature macro: FETCH_ADEL_EN
//   defined   -> a misaligned pc suppresses the RAM read and the instruction is
//                presented with adel=1, inst=0 so write-back can raise AdEL.
//   undefined -> no alignment check, adel tied to 0.
//
// Ports:
//   clk          in   clock, all state on posedge
//   resetn       in   synchronous active-low reset
//   ID_allow_in  in   decode can accept an instruction this cycle
//   jbr_bus      in   {taken, target[31:0]} from decode
//   exc_bus      in   {valid, target[31:0]} from write-back
//   cancel       in   flush from write-back
//   inst_en      out  instruction RAM read enable
//   inst_addr    out  instruction RAM address
//   inst_rdata   in   instruction RAM read data
//   IF_over      out  IF_ID_bus carries a valid instruction
//   IF_ID_bus    out  {adel, pc[31:0], inst[31:0]}, zero when IF_over=0
//   IF_pc        out  current PC register
//   IF_inst      out  instruction on IF_ID_bus
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ID_allow_in,
  input  logic [32:0] jbr_bus,
  input  logic [32:0] exc_bus,
  input  logic        cancel,
  output logic        inst_en,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  output logic        IF_over,
  output logic [64:0] IF_ID_bus,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_RESP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  logic        flush;
  logic        in_resp;
  logic        in_hold;
  logic        valid;
  logic        fire;
  logic [31:0] npc;
  logic [31:0] rd_addr;
  logic        rd_req;
  logic        rd_ok;
  logic        adel;
  logic [31:0] inst;

  assign flush   = cancel | exc_bus[32];
  assign in_resp = (state_q == S_RESP);
  assign in_hold = (state_q == S_HOLD);
  // Reset and flush both force the handoff off combinationally.
  assign valid   = resetn & ~flush & (in_resp | in_hold);
  assign fire    = valid & ID_allow_in;
  assign npc     = jbr_bus[32] ? jbr_bus[31:0] : pc_q + 32'd4;

  // In S_RESP the next read is overlapped with the handoff, so it targets npc.
  assign rd_addr = in_resp ? npc : pc_q;
  assign rd_req  = resetn & ~flush & ((state_q == S_REQ) | (in_resp & fire));

`ifdef FETCH_ADEL_EN
  assign rd_ok = (rd_addr[1:0] == 2'b00);
  assign adel  = (pc_q[1:0] != 2'b00);
`else
  assign rd_ok = 1'b1;
  assign adel  = 1'b0;
`endif

  assign inst_en   = rd_req & rd_ok;
  assign inst_addr = rd_addr;

  always_comb begin
    inst = 32'd0;
    if (!adel) begin
      inst = in_resp ? inst_rdata : inst_buf_q;
    end
  end

  assign IF_over   = valid;
  assign IF_ID_bus = valid ? {adel, pc_q, inst} : 65'd0;
  assign IF_inst   = valid ? inst : 32'd0;
  assign IF_pc     = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    if (flush) begin
      // Redirect on exception, otherwise refetch the current pc.
      if (exc_bus[32]) begin
        pc_d = exc_bus[31:0];
      end
      state_d    = S_REQ;
      inst_buf_d = 32'd0;
    end else begin
      case (state_q)
        S_REQ: state_d = S_RESP;
        S_RESP: begin
          if (fire) begin
            pc_d = npc;
          end else begin
            inst_buf_d = inst_rdata;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (fire) begin
            pc_d    = npc;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_buf_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: self-checking bench for fetch. A synchronous RAM model returns
// word index (addr >> 2); expected handoffs are queued as stimulus is driven
// and popped by a monitor whenever IF_over & ID_allow_in is seen.
module tb_fetch;

  logic        clk;
  logic        resetn;
  logic        ID_allow_in;
  logic [32:0] jbr_bus;
  logic [32:0] exc_bus;
  logic        cancel;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        IF_over;
  logic [64:0] IF_ID_bus;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;

  int unsigned n_checks;
  int unsigned n_fails;
  logic [64:0] exp_q[$];

  fetch dut (
    .clk         (clk),
    .resetn      (resetn),
    .ID_allow_in (ID_allow_in),
    .jbr_bus     (jbr_bus),
    .exc_bus     (exc_bus),
    .cancel      (cancel),
    .inst_en     (inst_en),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .IF_over     (IF_over),
    .IF_ID_bus   (IF_ID_bus),
    .IF_pc       (IF_pc),
    .IF_inst     (IF_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM word i holds value i.
  always @(posedge clk) begin
    if (inst_en) inst_rdata <= inst_addr >> 2;
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic adel, input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({adel, pc, inst});
  endtask

  // Scoreboard monitor: every handoff must match the oldest expectation.
  always @(negedge clk) begin
    if (IF_over === 1'b1 && ID_allow_in === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_handoff", IF_ID_bus, 65'd0);
      end else begin
        check("handoff", IF_ID_bus, exp_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] wrap_pc;

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    inst_rdata  = 32'd0;
    resetn      = 1'b0;
    ID_allow_in = 1'b1;
    jbr_bus     = 33'd0;
    exc_bus     = 33'd0;
    cancel      = 1'b0;
    wrap_pc     = 32'hFFFF_FFFC;

    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_inst_en", inst_en, 0);
    check("rst_if_over", IF_over, 0);
    check("rst_bus", IF_ID_bus, 0);
    check("rst_inst", IF_inst, 0);
    check("rst_pc", IF_pc, 32'h0);

    // Sequential fetch from reset.
    next_cycle(); resetn = 1'b1;
    push(1'b0, 32'h0, 32'd0); push(1'b0, 32'h4, 32'd1); push(1'b0, 32'h8, 32'd2);
    @(negedge clk);
    check("first_en", inst_en, 1); check("first_addr", inst_addr, 32'h0);
    check("first_nover", IF_over, 0);
    next_cycle(); @(negedge clk);
    check("b_over", IF_over, 1); check("b_addr", inst_addr, 32'h4);
    next_cycle(); @(negedge clk);
    check("c_addr", inst_addr, 32'h8);

    // Decode stall at pc=8 for 3 cycles.
    next_cycle(); ID_allow_in = 1'b0; @(negedge clk);
    check("stall_en0", inst_en, 0); check("stall_over", IF_over, 1);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); @(negedge clk);
      check("hold_bus", IF_ID_bus, {1'b0, 32'h8, 32'd2});
      check("hold_en0", inst_en, 0);
    end
    next_cycle(); ID_allow_in = 1'b1; @(negedge clk);
    check("release_en0", inst_en, 0);
    next_cycle(); push(1'b0, 32'hC, 32'd3); @(negedge clk);
    check("bubble_over", IF_over, 0); check("bubble_addr", inst_addr, 32'hC);
    check("bubble_en", inst_en, 1);

    // Branch taken on the fire of pc=12.
    next_cycle(); jbr_bus = {1'b1, 32'h40}; push(1'b0, 32'h40, 32'd16); @(negedge clk);
    check("br_addr", inst_addr, 32'h40);
    next_cycle(); jbr_bus = 33'd0; @(negedge clk);
    check("br_next_addr", inst_addr, 32'h44);

    // Stall at 0x44, then exception + cancel while held, with allow high.
    next_cycle(); ID_allow_in = 1'b0; @(negedge clk);
    check("k_pc", IF_pc, 32'h44);
    next_cycle(); ID_allow_in = 1'b1; exc_bus = {1'b1, 32'h380}; cancel = 1'b1;
    push(1'b0, 32'h380, 32'hE0);
    @(negedge clk);
    check("exc_over", IF_over, 0); check("exc_en", inst_en, 0);
    next_cycle(); exc_bus = 33'd0; cancel = 1'b0; @(negedge clk);
    check("exc_pc", IF_pc, 32'h380); check("exc_addr", inst_addr, 32'h380);
    check("exc_nover", IF_over, 0);
    next_cycle(); @(negedge clk);

    // Cancel alone refetches the current pc.
    next_cycle(); cancel = 1'b1; push(1'b0, 32'h384, 32'hE1); @(negedge clk);
    check("cancel_over", IF_over, 0);
    next_cycle(); cancel = 1'b0; @(negedge clk);
    check("refetch_pc", IF_pc, 32'h384); check("refetch_addr", inst_addr, 32'h384);
    next_cycle(); @(negedge clk);

    // exc_bus valid without cancel still flushes.
    next_cycle(); exc_bus = {1'b1, 32'h10}; push(1'b0, 32'h10, 32'd4); @(negedge clk);
    check("exc_only_over", IF_over, 0);
    next_cycle(); exc_bus = 33'd0; @(negedge clk);
    check("exc_only_addr", inst_addr, 32'h10);

    // PC wrap at the top of the address space.
    next_cycle(); jbr_bus = {1'b1, wrap_pc};
    push(1'b0, wrap_pc, wrap_pc >> 2); push(1'b0, 32'h0, 32'd0);
    @(negedge clk);
    check("wrap_br_addr", inst_addr, wrap_pc);
    next_cycle(); jbr_bus = 33'd0; @(negedge clk);
    check("wrap_addr", inst_addr, 32'h0);

    // Misaligned jump target.
    next_cycle(); jbr_bus = {1'b1, 32'h42};
`ifdef FETCH_ADEL_EN
    push(1'b1, 32'h42, 32'd0);
    @(negedge clk);
    check("adel_en0", inst_en, 0);
`else
    push(1'b0, 32'h42, 32'h10);
    @(negedge clk);
    check("mis_en", inst_en, 1); check("mis_addr", inst_addr, 32'h42);
`endif
    next_cycle(); jbr_bus = 33'd0; @(negedge clk);
    check("mis_over", IF_over, 1);

    // Reset mid-operation drops the pending fetch.
    next_cycle(); resetn = 1'b0; @(negedge clk);
    check("mid_rst_over", IF_over, 0); check("mid_rst_en", inst_en, 0);
    check("mid_rst_bus", IF_ID_bus, 0);
    next_cycle(); @(negedge clk);
    check("mid_rst_pc", IF_pc, 32'h0);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
